// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bus of the register file with busy scoreboard.
// The decode/writeback side is the master; the register file is the slave.
interface regfile_scoreboard_if #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD-1:0]      rd_use;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_busy;
    logic [NUM_WR-1:0]      wr_en;
    logic [NUM_WR*AW-1:0]   wr_addr;
    logic [NUM_WR*XLEN-1:0] wr_data;
    logic                   issue_en;
    logic [AW-1:0]          issue_rd;
    logic                   stall;
    logic [AW:0]            busy_cnt;

    modport master (
        output rd_addr, rd_use, wr_en, wr_addr, wr_data, issue_en, issue_rd,
        input  rd_data, rd_busy, stall, busy_cnt
    );

    modport slave (
        input  rd_addr, rd_use, wr_en, wr_addr, wr_data, issue_en, issue_rd,
        output rd_data, rd_busy, stall, busy_cnt
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with optional write-to-read bypass and a per-register
// busy scoreboard that stalls decode on RAW and WAW hazards.
module regfile_scoreboard #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int BYPASS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_scoreboard_if.slave  bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]        regs_q [NREGS];
    logic [NREGS-1:0]       busy_q, busy_d;
    logic [AW:0]            busy_cnt_q, busy_cnt_d;
    logic [NREGS-1:0]       clr_vec, set_vec;
    logic [NUM_RD*XLEN-1:0] rd_data_w;
    logic [NUM_RD-1:0]      rd_busy_w, rd_hit;
    logic                   waw_stall, stall_w, accept;
    logic [AW:0]            n_set, n_clr;

    // Later ports overwrite earlier ones, so the highest index wins on address clashes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] != '0)
                    regs_q[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        rd_data_w = '0;
        rd_busy_w = '0;
        rd_hit    = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_data_w[i*XLEN +: XLEN] = regs_q[bus.rd_addr[i*AW +: AW]];
            for (int j = 0; j < NUM_WR; j++) begin
                if (BYPASS != 0 && bus.wr_en[j] && bus.wr_addr[j*AW +: AW] != '0 &&
                    bus.wr_addr[j*AW +: AW] == bus.rd_addr[i*AW +: AW]) begin
                    rd_data_w[i*XLEN +: XLEN] = bus.wr_data[j*XLEN +: XLEN];
                    rd_hit[i] = 1'b1;
                end
            end
            if (bus.rd_addr[i*AW +: AW] == '0)
                rd_data_w[i*XLEN +: XLEN] = '0;
            rd_busy_w[i] = busy_q[bus.rd_addr[i*AW +: AW]] &&
                           bus.rd_addr[i*AW +: AW] != '0 && !rd_hit[i];
        end
    end

    always_comb begin
        clr_vec = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] != '0)
                clr_vec[bus.wr_addr[j*AW +: AW]] = 1'b1;
        end
    end

    // A write landing on the issue target this cycle retires the old producer, so no WAW.
    assign waw_stall = bus.issue_en && bus.issue_rd != '0 &&
                       busy_q[bus.issue_rd] && !clr_vec[bus.issue_rd];
    assign stall_w   = (|(bus.rd_use & rd_busy_w)) || waw_stall;
    assign accept    = bus.issue_en && !stall_w && bus.issue_rd != '0;

    always_comb begin
        set_vec = '0;
        if (accept) set_vec[bus.issue_rd] = 1'b1;
    end

    // Set wins over clear on the same register; the count then nets to zero.
    assign busy_d = (busy_q & ~clr_vec) | set_vec;

    always_comb begin
        n_set = '0;
        n_clr = '0;
        for (int r = 0; r < NREGS; r++) begin
            if (set_vec[r] && !busy_q[r])              n_set = n_set + (AW+1)'(1);
            if (clr_vec[r] && busy_q[r] && !set_vec[r]) n_clr = n_clr + (AW+1)'(1);
        end
        busy_cnt_d = busy_cnt_q + n_set - n_clr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign bus.rd_data  = rd_data_w;
    assign bus.rd_busy  = rd_busy_w;
    assign bus.stall    = stall_w;
    assign bus.busy_cnt = busy_cnt_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: one bypassing and one non-bypassing instance share the same stimulus.
module tb_regfile_scoreboard;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2*AW-1:0]   rd_addr;
    logic [1:0]        rd_use;
    logic [1:0]        wr_en;
    logic [2*AW-1:0]   wr_addr;
    logic [2*XLEN-1:0] wr_data;
    logic              issue_en;
    logic [AW-1:0]     issue_rd;

    int n_checks = 0;
    int n_errors = 0;

    regfile_scoreboard_if #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2)) if_b1 ();
    regfile_scoreboard_if #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2)) if_b0 ();

    assign if_b1.rd_addr  = rd_addr;   assign if_b0.rd_addr  = rd_addr;
    assign if_b1.rd_use   = rd_use;    assign if_b0.rd_use   = rd_use;
    assign if_b1.wr_en    = wr_en;     assign if_b0.wr_en    = wr_en;
    assign if_b1.wr_addr  = wr_addr;   assign if_b0.wr_addr  = wr_addr;
    assign if_b1.wr_data  = wr_data;   assign if_b0.wr_data  = wr_data;
    assign if_b1.issue_en = issue_en;  assign if_b0.issue_en = issue_en;
    assign if_b1.issue_rd = issue_rd;  assign if_b0.issue_rd = issue_rd;

    regfile_scoreboard #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1))
        dut_b1 (.clk(clk), .rst(rst), .bus(if_b1));
    regfile_scoreboard #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(0))
        dut_b0 (.clk(clk), .rst(rst), .bus(if_b0));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rd_use = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        issue_en = 1'b0; issue_rd = '0;
    endtask

    // Advance one edge, then settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rd_addr = '0;
        #12;
        check("rst_cnt_b1", 64'(if_b1.busy_cnt), 64'd0);
        check("rst_stall_b1", 64'(if_b1.stall), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // write/read with bypass
        wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'hDEADBEEF};
        rd_addr = {5'd0, 5'd3};
        #1;
        check("byp_b1", 64'(if_b1.rd_data[31:0]), 64'hDEADBEEF);
        check("byp_b0", 64'(if_b0.rd_data[31:0]), 64'h0);
        step(); idle(); #1;
        check("rd3_b1", 64'(if_b1.rd_data[31:0]), 64'hDEADBEEF);
        check("rd3_b0", 64'(if_b0.rd_data[31:0]), 64'hDEADBEEF);

        // port priority on reg 7
        wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11};
        rd_addr = {5'd7, 5'd3};
        #1;
        check("prio_byp_b1", 64'(if_b1.rd_data[63:32]), 64'h22);
        check("prio_byp_b0", 64'(if_b0.rd_data[63:32]), 64'h0);
        step(); idle(); #1;
        check("prio_b1", 64'(if_b1.rd_data[63:32]), 64'h22);
        check("prio_b0", 64'(if_b0.rd_data[63:32]), 64'h22);

        // RAW on reg 9
        issue_en = 1'b1; issue_rd = 5'd9;
        #1;
        check("raw_issue_stall", 64'(if_b1.stall), 64'd0);
        step(); idle();
        rd_addr = {5'd9, 5'd0}; rd_use = 2'b10;
        #1;
        check("raw_cnt", 64'(if_b1.busy_cnt), 64'd1);
        check("raw_busy", 64'(if_b1.rd_busy), 64'b10);
        check("raw_stall_b1", 64'(if_b1.stall), 64'd1);
        check("raw_stall_b0", 64'(if_b0.stall), 64'd1);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'hAB};
        #1;
        check("raw_wb_stall_b1", 64'(if_b1.stall), 64'd0);
        check("raw_wb_data_b1", 64'(if_b1.rd_data[63:32]), 64'hAB);
        check("raw_wb_stall_b0", 64'(if_b0.stall), 64'd1);
        step(); idle(); #1;
        check("raw_cnt_after_b1", 64'(if_b1.busy_cnt), 64'd0);
        check("raw_cnt_after_b0", 64'(if_b0.busy_cnt), 64'd0);
        check("raw_rd_b0", 64'(if_b0.rd_data[63:32]), 64'hAB);

        // WAW on reg 4, then set-wins
        issue_en = 1'b1; issue_rd = 5'd4;
        step(); #1;
        check("waw_cnt1", 64'(if_b1.busy_cnt), 64'd1);
        check("waw_stall", 64'(if_b1.stall), 64'd1);
        step(); idle(); #1;
        check("waw_ignored_cnt", 64'(if_b1.busy_cnt), 64'd1);
        issue_en = 1'b1; issue_rd = 5'd4;
        wr_en = 2'b10; wr_addr = {5'd4, 5'd0}; wr_data = {32'h44, 32'h0};
        #1;
        check("setwin_stall", 64'(if_b1.stall), 64'd0);
        step(); idle();
        rd_addr = {5'd0, 5'd4};
        #1;
        check("setwin_cnt", 64'(if_b1.busy_cnt), 64'd1);
        check("setwin_busy", 64'(if_b1.rd_busy), 64'b01);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'h45};
        step(); idle(); #1;
        check("clr4_cnt", 64'(if_b1.busy_cnt), 64'd0);

        // x0 handling
        wr_en = 2'b01; wr_addr = '0; wr_data = {32'h0, 32'hFFFFFFFF};
        issue_en = 1'b1; issue_rd = 5'd0; rd_addr = '0;
        #1;
        check("x0_byp", 64'(if_b1.rd_data[31:0]), 64'h0);
        check("x0_stall", 64'(if_b1.stall), 64'd0);
        step(); idle(); #1;
        check("x0_rd", 64'(if_b1.rd_data[31:0]), 64'h0);
        check("x0_cnt", 64'(if_b1.busy_cnt), 64'd0);

        // async reset mid-cycle with live state
        issue_en = 1'b1; issue_rd = 5'd5;
        step(); idle();
        rd_addr = {5'd3, 5'd5};
        #1;
        check("pre_rst_busy", 64'(if_b1.rd_busy), 64'b01);
        check("pre_rst_data", 64'(if_b1.rd_data[63:32]), 64'hDEADBEEF);
        rst = 1'b1;
        #1;
        check("arst_data", 64'(if_b1.rd_data), 64'h0);
        check("arst_busy", 64'(if_b1.rd_busy), 64'b00);
        check("arst_cnt", 64'(if_b1.busy_cnt), 64'd0);
        rst = 1'b0;
        issue_en = 1'b1; issue_rd = 5'd6;
        step(); idle(); #1;
        check("post_rst_cnt", 64'(if_b1.busy_cnt), 64'd1);
        check("post_rst_busy5", 64'(if_b1.rd_busy), 64'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
